// File: rtl/impulse_playback_if.sv
// BRAM read port between the impulse playback engine (master) and the IR buffer (slave).
interface impulse_playback_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic                     read_en;
  logic [ADDR_W-1:0]        read_addr;
  logic signed [15:0]       read_data;

  modport master (
    output read_en,
    output read_addr,
    input  read_data
  );

  modport slave (
    input  read_en,
    input  read_addr,
    output read_data
  );
endinterface

// File: rtl/impulse_playback.sv
// Streams a stored impulse response out of the IR buffer BRAM, one sample per audio_trigger,
// with one-shot or looped playback and abort.
module impulse_playback #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic                audio_clk,
  input  logic                rst_n_in,
  input  logic                audio_trigger,
  input  logic                impulse_recorded,
  input  logic [15:0]         impulse_length,
  input  logic                play_trigger,
  input  logic                stop_in,
  input  logic                loop_en,
  impulse_playback_if.master  bram,
  output logic signed [15:0]  sample_out,
  output logic                sample_valid,
  output logic                playing,
  output logic                playback_done
);

  typedef enum logic [1:0] {StIdle, StPlaying, StDrain} state_e;

  localparam logic [READ_LATENCY-1:0] TopBit = READ_LATENCY'(1) << (READ_LATENCY - 1);

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         index_q, index_d;
  logic [15:0]               len_q, len_d;
  logic                      read_en_q, read_en_d;
  logic [ADDR_W-1:0]         read_addr_q, read_addr_d;
  logic [READ_LATENCY-1:0]   tag_q, tag_d;
  logic signed [15:0]        sample_out_q, sample_out_d;
  logic                      sample_valid_q, sample_valid_d;
  logic                      done_q, done_d;

  logic [15:0] len_m1;
  logic        at_last;
  logic        tag_exit;
  logic        tag_others;
  logic        abort;

  assign len_m1     = len_q - 16'd1;
  assign at_last    = (index_q == ADDR_W'(len_m1));
  assign tag_exit   = tag_q[READ_LATENCY-1];
  assign tag_others = |(tag_q & ~TopBit);
  assign abort      = (state_q != StIdle) && (stop_in || !impulse_recorded);

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    len_d          = len_q;
    read_en_d      = 1'b0;
    read_addr_d    = read_addr_q;
    tag_d          = '0;
    tag_d[0]       = read_en_q;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    sample_out_d   = tag_exit ? bram.read_data : sample_out_q;
    sample_valid_d = tag_exit;
    done_d         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (play_trigger && !stop_in && impulse_recorded && (impulse_length != 16'd0)) begin
          len_d   = impulse_length;
          index_d = '0;
          state_d = StPlaying;
        end
      end
      StPlaying: begin
        if (audio_trigger) begin
          read_en_d   = 1'b1;
          read_addr_d = index_q;
          if (at_last) begin
            index_d = '0;
            if (!loop_en) state_d = StDrain;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // The final read is the only one left once nothing else is queued behind it.
        if (tag_exit && !tag_others && !read_en_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if ((tag_q == '0) && !read_en_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort drops in-flight reads and mutes the output.
    if (abort) begin
      state_d        = StIdle;
      read_en_d      = 1'b0;
      tag_d          = '0;
      sample_out_d   = '0;
      sample_valid_d = 1'b0;
      done_d         = 1'b0;
    end
  end

  always_ff @(posedge audio_clk) begin
    if (!rst_n_in) begin
      state_q        <= StIdle;
      index_q        <= '0;
      len_q          <= '0;
      read_en_q      <= 1'b0;
      read_addr_q    <= '0;
      tag_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      len_q          <= len_d;
      read_en_q      <= read_en_d;
      read_addr_q    <= read_addr_d;
      tag_q          <= tag_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
    end
  end

  assign bram.read_en   = read_en_q;
  assign bram.read_addr = read_addr_q;
  assign sample_out     = sample_out_q;
  assign sample_valid   = sample_valid_q;
  assign playback_done  = done_q;
  assign playing        = (state_q != StIdle);

endmodule

// File: tb/tb_impulse_playback.sv
// Scoreboard bench for impulse_playback: triggers push expected samples, a monitor pops and checks.
module tb_impulse_playback;
  localparam int unsigned RL = 2;
  localparam int unsigned AW = 16;

  typedef struct {
    logic signed [15:0] val;
    logic               done;
    int                 cyc;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               audio_trigger;
  logic               impulse_recorded;
  logic [15:0]        impulse_length;
  logic               play_trigger;
  logic               stop_in;
  logic               loop_en;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               playing;
  logic               playback_done;

  int n_tests;
  int n_fail;
  int cyc;
  int rd_cnt;
  int done_cnt;
  int base_rd;
  int base_done;
  exp_t sbq[$];
  logic [15:0] rd_log[$];

  logic signed [15:0] os_vals  [4] = '{16'sd0, 16'sd3, 16'sd6, 16'sd9};
  logic signed [15:0] lp_vals  [7] = '{16'sd0, 16'sd3, 16'sd6, 16'sd0, 16'sd3, 16'sd6, 16'sd0};
  logic [15:0]        lp_addr  [7] = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
  logic signed [15:0] rst_vals [5] = '{16'sd0, 16'sd3, 16'sd6, 16'sd9, 16'sd12};

  impulse_playback_if #(.ADDR_W(AW)) bram ();

  impulse_playback #(.READ_LATENCY(RL), .ADDR_W(AW)) dut (
    .audio_clk        (clk),
    .rst_n_in         (rst_n),
    .audio_trigger    (audio_trigger),
    .impulse_recorded (impulse_recorded),
    .impulse_length   (impulse_length),
    .play_trigger     (play_trigger),
    .stop_in          (stop_in),
    .loop_en          (loop_en),
    .bram             (bram.master),
    .sample_out       (sample_out),
    .sample_valid     (sample_valid),
    .playing          (playing),
    .playback_done    (playback_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM with mem[i] = i*3 and a RL-stage read pipeline.
  logic signed [15:0] pipe [RL];
  always @(posedge clk) begin
    if (bram.read_en) pipe[0] <= 16'(32'(bram.read_addr) * 3);
    for (int i = 1; i < int'(RL); i++) pipe[i] <= pipe[i-1];
  end
  assign bram.read_data = pipe[RL-1];

  // Monitor: pops the scoreboard on every sample_valid.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bram.read_en) begin
      rd_cnt++;
      rd_log.push_back(bram.read_addr);
    end
    if (playback_done) done_cnt++;
    if (sample_valid) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_sample got=%0d done=%0d cyc=%0d required=no pulse",
                 sample_out, playback_done, cyc);
      end else begin
        e = sbq.pop_front();
        if (sample_out !== e.val || playback_done !== e.done || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL sample got val=%0d done=%0d cyc=%0d required val=%0d done=%0d cyc=%0d",
                   sample_out, playback_done, cyc, e.val, e.done, e.cyc);
        end
      end
    end else if (playback_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL stray_done got=1 required=0 cyc=%0d", cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic play();
    @(negedge clk) play_trigger = 1'b1;
    @(negedge clk) play_trigger = 1'b0;
  endtask

  task automatic stop();
    @(negedge clk) stop_in = 1'b1;
    @(negedge clk) stop_in = 1'b0;
  endtask

  // One audio_trigger, optionally expecting a sample RL+1 cycles later; then idle out the period.
  task automatic trig(input bit exp_s, input logic signed [15:0] v, input bit d);
    exp_t e;
    @(negedge clk);
    audio_trigger = 1'b1;
    if (exp_s) begin
      e.val  = v;
      e.done = d;
      e.cyc  = cyc + int'(RL) + 2;
      sbq.push_back(e);
    end
    @(negedge clk) audio_trigger = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; rd_cnt = 0; done_cnt = 0;
    rst_n = 1'b0; audio_trigger = 1'b0; impulse_recorded = 1'b1; impulse_length = 16'd0;
    play_trigger = 1'b0; stop_in = 1'b0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_read_en", bram.read_en, 0);
    check("rst_read_addr", bram.read_addr, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_playing", playing, 0);
    check("rst_done", playback_done, 0);

    // One-shot, length 4.
    impulse_length = 16'd4; loop_en = 1'b0; base_rd = rd_cnt;
    play();
    check("oneshot_playing", playing, 1);
    for (int i = 0; i < 4; i++) trig(1'b1, os_vals[i], i == 3);
    check("oneshot_playing_low", playing, 0);
    check("oneshot_reads", rd_cnt - base_rd, 4);

    // Looped, length 3, 7 triggers.
    impulse_length = 16'd3; loop_en = 1'b1; rd_log.delete(); base_done = done_cnt;
    play();
    for (int i = 0; i < 7; i++) trig(1'b1, lp_vals[i], 1'b0);
    check("loop_read_count", rd_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check("loop_addr", (rd_log.size() > i) ? rd_log[i] : 16'hffff, lp_addr[i]);
    end
    check("loop_still_playing", playing, 1);
    check("loop_no_done", done_cnt - base_done, 0);
    stop();
    check("loop_stop_idle", playing, 0);

    // Abort one cycle after a read_en.
    impulse_length = 16'd4; loop_en = 1'b0; base_done = done_cnt;
    play();
    trig(1'b1, 16'sd0, 1'b0);
    trig(1'b1, 16'sd3, 1'b0);
    check("abort_pre_sample", sample_out, 3);
    @(negedge clk) audio_trigger = 1'b1;
    @(negedge clk) begin
      audio_trigger = 1'b0;
      check("abort_read_en_seen", bram.read_en, 1);
      stop_in = 1'b1;
    end
    @(negedge clk) stop_in = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_mute", sample_out, 0);
    check("abort_idle", playing, 0);
    check("abort_no_done", done_cnt - base_done, 0);

    // Rejected starts.
    base_rd = rd_cnt;
    impulse_recorded = 1'b0; impulse_length = 16'd4;
    play();
    trig(1'b0, 16'sd0, 1'b0);
    check("reject_unrecorded", playing, 0);
    impulse_recorded = 1'b1; impulse_length = 16'd0;
    play();
    trig(1'b0, 16'sd0, 1'b0);
    check("reject_len0", playing, 0);
    impulse_length = 16'd4;
    @(negedge clk) begin play_trigger = 1'b1; stop_in = 1'b1; end
    @(negedge clk) begin play_trigger = 1'b0; stop_in = 1'b0; end
    check("reject_play_stop", playing, 0);
    trig(1'b0, 16'sd0, 1'b0);
    check("reject_no_reads", rd_cnt - base_rd, 0);

    // Length 1.
    impulse_length = 16'd1; base_rd = rd_cnt;
    play();
    trig(1'b1, 16'sd0, 1'b1);
    trig(1'b0, 16'sd0, 1'b0);
    check("len1_reads", rd_cnt - base_rd, 1);
    check("len1_idle", playing, 0);

    // Length latched at start: 4 -> 8 mid-playback.
    impulse_length = 16'd4; base_rd = rd_cnt;
    play();
    trig(1'b1, 16'sd0, 1'b0);
    impulse_length = 16'd8;
    trig(1'b1, 16'sd3, 1'b0);
    trig(1'b1, 16'sd6, 1'b0);
    trig(1'b1, 16'sd9, 1'b1);
    trig(1'b0, 16'sd0, 1'b0);
    check("latch_reads", rd_cnt - base_rd, 4);
    check("latch_idle", playing, 0);

    // Reset mid-playback at index 5 with a read in flight.
    impulse_length = 16'd8;
    play();
    for (int i = 0; i < 5; i++) trig(1'b1, rst_vals[i], 1'b0);
    @(negedge clk) audio_trigger = 1'b1;
    @(negedge clk) begin audio_trigger = 1'b0; rst_n = 1'b0; end
    @(negedge clk) rst_n = 1'b1;
    check("midrst_read_en", bram.read_en, 0);
    check("midrst_read_addr", bram.read_addr, 0);
    check("midrst_sample_out", sample_out, 0);
    check("midrst_sample_valid", sample_valid, 0);
    check("midrst_playing", playing, 0);
    check("midrst_done", playback_done, 0);
    repeat (10) @(negedge clk);
    check("midrst_still_idle", playing, 0);

    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/impulse_playback.md
Name: impulse_playback

Overview:
- Read-side counterpart of the impulse recorder. Once an impulse response is in the IR buffer BRAM, this block streams it back out.
- Streaming is sequential, one sample per audio_trigger, from address 0 to impulse_length-1.
- Output samples feed monitoring/DAC and convolution verification.
- Supports one-shot and looped playback, abort, and a BRAM read port with fixed latency.

Parameters:
- READ_LATENCY, 2, cycles from read_en/read_addr to valid read_data (1..4).
- ADDR_W, 16, BRAM address width.

Ports:
- audio_clk  in  1  system audio clock; only clock in block
- rst_n_in  in  1  reset, synchronous, active-low
- audio_trigger  in  1  one-cycle sample-rate strobe
- impulse_recorded  in  1  level; high while a complete IR is stored
- impulse_length  in  16  number of stored samples
- play_trigger  in  1  one-cycle start request
- stop_in  in  1  one-cycle abort request
- loop_en  in  1  level; wrap to address 0 instead of finishing
- read_en  out  1  BRAM read strobe
- read_addr  out  ADDR_W  BRAM read address
- read_data  in  16  BRAM read data, signed
- sample_out  out  16  signed sample; holds between updates
- sample_valid  out  1  one-cycle pulse when sample_out updates
- playing  out  1  high in PLAYING or DRAIN
- playback_done  out  1  one-cycle pulse at end of one-shot playback

Behaviour:
- Only clock: audio_clk. rst_n_in is synchronous, active-low, sampled on the rising edge of audio_clk.
- Reset (rst_n_in=0 at edge) values: state=IDLE; read_en=0, read_addr=0, sample_out=0, sample_valid=0, playing=0, playback_done=0; index=0; in-flight tag pipeline cleared.
- States: IDLE, PLAYING, DRAIN.
- IDLE:
  - play_trigger with impulse_recorded=1 and impulse_length!=0: latch len_q=impulse_length, index=0, go PLAYING.
  - Otherwise play_trigger is ignored.
- PLAYING, on audio_trigger:
  - Drive read_en=1 for exactly that cycle, read_addr=index.
  - If index==len_q-1 and loop_en=1: index wraps to 0, stay PLAYING.
  - If index==len_q-1 and loop_en=0: go DRAIN.
  - Else index+1.
  - read_en=0 on all other cycles.
- Tag pipeline: each read_en pushes a 1 into a READ_LATENCY-deep shift register; empty cycles push 0.
  - When the tag exits (exactly READ_LATENCY cycles after read_en), sample_out<=read_data and sample_valid=1 for one cycle.
  - Total latency audio_trigger -> sample_valid = READ_LATENCY+1 cycles (read_en is registered).
- DRAIN: when the last tag exits (sample_valid of final sample), assert playback_done for one cycle, same cycle as that sample_valid; go IDLE, playing=0 next cycle.
- Abort: stop_in=1, or impulse_recorded=0, in PLAYING/DRAIN:
  - Next state IDLE; tag pipeline cleared, so in-flight reads produce no sample_valid.
  - sample_out<=0 (mute); playback_done not asserted.
- Simultaneous events:
  - stop_in and play_trigger same cycle in IDLE: stop wins, stay IDLE.
  - play_trigger while PLAYING/DRAIN: ignored.
  - loop_en is sampled only at the wrap point.
- impulse_length is latched at start; changes mid-playback have no effect.
- len_q=1 one-shot: one read, then DRAIN.
- audio_trigger spacing is guaranteed > READ_LATENCY+1 cycles. Behaviour under closer spacing is undefined, but the FSM must not hang.
- Arithmetic: index is ADDR_W unsigned, compared to len_q-1. len_q=0 never enters PLAYING.

Test Plan:
- Reset mid-PLAYING: assert rst_n_in=0 one cycle at index=5 -> all outputs 0 next cycle, no sample_valid for 10 cycles after.
- BRAM model with mem[i]=i*3, impulse_length=4, loop_en=0, triggers every 20 cycles:
  - sample_valid pulses carry 0,3,6,9, each READ_LATENCY+1 cycles after its trigger.
  - playback_done coincides with the value-9 pulse; playing low afterward.
- loop_en=1, impulse_length=3 -> read_addr sequence 0,1,2,0,1,2,0 across 7 triggers; no playback_done.
- stop_in one cycle after a read_en -> no sample_valid for that read, sample_out=0, state IDLE, playback_done stays 0.
- play_trigger with impulse_recorded=0, or impulse_length=0 -> read_en never asserts, playing stays 0; play_trigger+stop_in in the same cycle -> stays IDLE.
- impulse_length=1, and separately impulse_length changed 4->8 mid-playback -> exactly 1 and exactly 4 samples respectively, each followed by playback_done.
